// File: rtl/clint_access_master_pkg.sv
// CLINT memory map, MMIO address type and timer-access command codes
// shared by the access master and its users.
package clint_access_master_pkg;

    typedef logic [31:0] Addr;

    localparam Addr CLINT_BASE      = 32'h0200_0000;
    localparam Addr CLINT_MTIMECMP  = CLINT_BASE + 32'h0000_4000;
    localparam Addr CLINT_MTIMECMPH = CLINT_BASE + 32'h0000_4004;
    localparam Addr CLINT_MTIME     = CLINT_BASE + 32'h0000_BFF8;
    localparam Addr CLINT_MTIMEH    = CLINT_BASE + 32'h0000_BFFC;

    typedef enum logic [1:0] {
        RD_MTIME    = 2'd0,
        RD_MTIMECMP = 2'd1,
        WR_MTIMECMP = 2'd2,
        OP_RSVD     = 2'd3
    } ClintOp;

    typedef struct packed {
        Addr         addr;
        logic        wen;
        logic [31:0] wdata;
    } MmioReq;

    // Reads go H,L,H; writes park the low word at all-ones before touching H.
    function automatic MmioReq access_for(input ClintOp op, input logic [1:0] step,
                                          input logic [63:0] wdata);
        MmioReq r;
        Addr    lo_a;
        Addr    hi_a;
        r    = '0;
        lo_a = (op == RD_MTIMECMP) ? CLINT_MTIMECMP  : CLINT_MTIME;
        hi_a = (op == RD_MTIMECMP) ? CLINT_MTIMECMPH : CLINT_MTIMEH;
        if (op == WR_MTIMECMP) begin
            r.wen = 1'b1;
            case (step)
                2'd0: begin
                    r.addr  = CLINT_MTIMECMP;
                    r.wdata = '1;
                end
                2'd1: begin
                    r.addr  = CLINT_MTIMECMPH;
                    r.wdata = wdata[63:32];
                end
                default: begin
                    r.addr  = CLINT_MTIMECMP;
                    r.wdata = wdata[31:0];
                end
            endcase
        end else begin
            r.addr = (step == 2'd1) ? lo_a : hi_a;
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_access_master.sv
// Sequences one 64-bit CLINT timer command into tear-free 32-bit MMIO
// accesses (hi-lo-hi read with retry, safe-order mtimecmp write).
module clint_access_master
    import clint_access_master_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_wdata,
    output logic        done_valid,
    output logic [63:0] done_rdata,
    output logic        done_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    logic [1:0]    r_state;
    logic [1:0]    r_step;
    ClintOp        r_op;
    logic [63:0]   r_wdata;
    logic [31:0]   r_hi1;
    logic [31:0]   r_lo;
    logic [RW-1:0] r_retry;
    MmioReq        r_req;
    logic [63:0]   r_done_rdata;
    logic          r_done_err;

    ClintOp        w_cmd_op;
    logic [1:0]    w_next_step;
    MmioReq        w_next_req;

    assign w_cmd_op = ClintOp'(cmd_op);

    // Step 2 only loops back (to step 1) on a read retry; a write finishes there.
    always_comb begin
        w_next_step = (r_step == 2'd2) ? 2'd1 : r_step + 2'd1;
        if (r_state == S_IDLE) begin
            w_next_req = access_for(w_cmd_op, 2'd0, cmd_wdata);
        end else begin
            w_next_req = access_for(r_op, w_next_step, r_wdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_op         <= RD_MTIME;
            r_wdata      <= '0;
            r_hi1        <= '0;
            r_lo         <= '0;
            r_retry      <= '0;
            r_req        <= '0;
            r_done_rdata <= '0;
            r_done_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= w_cmd_op;
                        r_wdata <= cmd_wdata;
                        r_retry <= '0;
                        r_step  <= '0;
                        if (w_cmd_op == OP_RSVD) begin
                            r_state      <= S_DONE;
                            r_done_rdata <= '0;
                            r_done_err   <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_req   <= w_next_req;
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        if (r_op == WR_MTIMECMP) begin
                            if (r_step == 2'd2) begin
                                r_state      <= S_DONE;
                                r_done_rdata <= '0;
                                r_done_err   <= 1'b0;
                            end else begin
                                r_state <= S_ISSUE;
                                r_step  <= w_next_step;
                                r_req   <= w_next_req;
                            end
                        end else begin
                            case (r_step)
                                2'd0: begin
                                    r_hi1   <= resp_rdata;
                                    r_state <= S_ISSUE;
                                    r_step  <= w_next_step;
                                    r_req   <= w_next_req;
                                end
                                2'd1: begin
                                    r_lo    <= resp_rdata;
                                    r_state <= S_ISSUE;
                                    r_step  <= w_next_step;
                                    r_req   <= w_next_req;
                                end
                                default: begin
                                    if (resp_rdata == r_hi1) begin
                                        r_state      <= S_DONE;
                                        r_done_rdata <= {r_hi1, r_lo};
                                        r_done_err   <= 1'b0;
                                    end else if (r_retry == RETRY_LIMIT) begin
                                        r_state      <= S_DONE;
                                        r_done_rdata <= {resp_rdata, r_lo};
                                        r_done_err   <= 1'b1;
                                    end else begin
                                        r_hi1   <= resp_rdata;
                                        r_retry <= r_retry + 1'b1;
                                        r_state <= S_ISSUE;
                                        r_step  <= w_next_step;
                                        r_req   <= w_next_req;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign req_valid  = (r_state == S_ISSUE);
    assign done_valid = (r_state == S_DONE);
    assign req_addr   = r_req.addr;
    assign req_wen    = r_req.wen;
    assign req_wdata  = r_req.wdata;
    assign done_rdata = r_done_rdata;
    assign done_err   = r_done_err;

endmodule

// File: tb/tb_clint_access_master.sv
// Directed bench for clint_access_master with a behavioural CLINT responder.
module tb_clint_access_master;
    import clint_access_master_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_wdata;
    logic        done_valid;
    logic [63:0] done_rdata;
    logic        done_err;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    clint_access_master #(.MAX_RETRY(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cmd_wdata),
        .done_valid (done_valid),
        .done_rdata (done_rdata),
        .done_err   (done_err),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Device model state: mode 0 static, 1 mtime rolls after the first H read,
    // 2 mtime high word increments after every H read.
    logic [63:0] m_mtime;
    logic [63:0] m_mtimecmp;
    int          mode = 0;
    bit          stall = 0;
    bit          roll_armed = 0;

    logic [31:0] log_addr  [0:63];
    logic        log_wen   [0:63];
    logic [31:0] log_wdata [0:63];
    int          n_acc = 0;
    int          n_done = 0;
    int          stab_err = 0;
    int          outst_err = 0;

    logic [31:0] rd_data;
    logic [31:0] acc_addr;
    logic        acc_wen;
    logic [31:0] acc_wdata;

    task automatic do_access();
        if (n_acc < 64) begin
            log_addr[n_acc]  = acc_addr;
            log_wen[n_acc]   = acc_wen;
            log_wdata[n_acc] = acc_wdata;
        end
        n_acc++;
        rd_data = 32'hDEAD_BEEF;
        case (acc_addr)
            CLINT_MTIME: rd_data = m_mtime[31:0];
            CLINT_MTIMEH: begin
                rd_data = m_mtime[63:32];
                if (mode == 1 && roll_armed) begin
                    m_mtime    = 64'h0000_0001_0000_0000;
                    roll_armed = 0;
                end
                if (mode == 2) m_mtime[63:32] = m_mtime[63:32] + 32'd1;
            end
            CLINT_MTIMECMP: begin
                if (acc_wen) m_mtimecmp[31:0] = acc_wdata;
                else rd_data = m_mtimecmp[31:0];
            end
            CLINT_MTIMECMPH: begin
                if (acc_wen) m_mtimecmp[63:32] = acc_wdata;
                else rd_data = m_mtimecmp[63:32];
            end
            default: ;
        endcase
    endtask

    // Responder: drives on the falling edge; garbage resp_valid outside WAIT.
    initial begin
        bit          pending;
        bit          acc_pend;
        bit          have_prev;
        int          dly;
        int          wait_cnt;
        logic [31:0] p_addr;
        logic        p_wen;
        logic [31:0] p_wdata;
        pending = 0; acc_pend = 0; have_prev = 0; dly = 0; wait_cnt = 0;
        p_addr = '0; p_wen = 1'b0; p_wdata = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 0; acc_pend = 0; have_prev = 0; dly = 0; wait_cnt = 0;
                req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
            end else begin
                if (acc_pend) begin
                    do_access();
                    pending = 1;
                    dly = stall ? 2 : 0;
                end else if (pending && resp_valid) begin
                    pending = 0;
                end
                if (req_valid && pending) outst_err++;
                if (req_valid) begin
                    if (have_prev && (req_addr !== p_addr || req_wen !== p_wen || req_wdata !== p_wdata))
                        stab_err++;
                    have_prev = 1; p_addr = req_addr; p_wen = req_wen; p_wdata = req_wdata;
                end else begin
                    have_prev = 0;
                end
                if (req_valid && !pending) begin
                    if (stall && wait_cnt < 3) begin
                        req_ready = 1'b0;
                        wait_cnt++;
                    end else begin
                        req_ready = 1'b1;
                        wait_cnt = 0;
                    end
                end else begin
                    req_ready = !stall;
                end
                acc_pend = req_valid && req_ready;
                acc_addr = req_addr; acc_wen = req_wen; acc_wdata = req_wdata;
                if (pending && dly == 0) begin
                    resp_valid = 1'b1;
                    resp_rdata = rd_data;
                end else if (pending) begin
                    dly--;
                    resp_valid = 1'b0;
                    resp_rdata = 32'hDEAD_BEEF;
                end else begin
                    resp_valid = 1'b1;
                    resp_rdata = 32'hDEAD_BEEF;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done_valid) n_done++;
        end
    end

    // lat counts cycles inclusively: the accept cycle is 1, the DONE cycle is lat.
    task automatic run_cmd(input logic [1:0] op, input logic [63:0] wd, input bit poke,
                           output int lat, output logic [63:0] rd, output logic er);
        int d0;
        d0 = n_done;
        n_acc = 0;
        @(negedge clk);
        cmd_op = op; cmd_wdata = wd; cmd_valid = 1'b1;
        check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 2;
        while (!done_valid && lat < 300) begin
            if (poke && lat == 4) begin cmd_valid = 1'b1; cmd_op = 2'd3; end
            if (poke && lat == 6) cmd_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("done_seen", 64'(done_valid), 64'd1);
        rd = done_rdata;
        er = done_err;
        @(posedge clk); #1;
        check_eq("done_one_cycle", 64'(done_valid), 64'd0);
        check_eq("done_pulses", 64'(n_done - d0), 64'd1);
    endtask

    int          lat;
    logic [63:0] rd;
    logic        er;
    int          d_before;
    int          tmo;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = '0;
        m_mtime = '0; m_mtimecmp = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("rst_req_wen", 64'(req_wen), 64'd0);
        check_eq("rst_req_addr", 64'(req_addr), 64'd0);
        check_eq("rst_req_wdata", 64'(req_wdata), 64'd0);
        check_eq("rst_done_valid", 64'(done_valid), 64'd0);
        check_eq("rst_done_rdata", done_rdata, 64'd0);
        check_eq("rst_done_err", 64'(done_err), 64'd0);
        #2 rst_n = 1'b1;

        // Clean read of a static mtime
        mode = 0; m_mtime = 64'h0000_0001_0000_0010;
        run_cmd(2'd0, 64'd0, 0, lat, rd, er);
        check_eq("rd_lat", 64'(lat), 64'd8);
        check_eq("rd_data", rd, 64'h0000_0001_0000_0010);
        check_eq("rd_err", 64'(er), 64'd0);
        check_eq("rd_nacc", 64'(n_acc), 64'd3);
        check_eq("rd_addr0", 64'(log_addr[0]), 64'h0200_BFFC);
        check_eq("rd_addr1", 64'(log_addr[1]), 64'h0200_BFF8);
        check_eq("rd_addr2", 64'(log_addr[2]), 64'h0200_BFFC);
        check_eq("rd_wen", 64'({log_wen[0], log_wen[1], log_wen[2]}), 64'd0);
        repeat (3) @(posedge clk); #1;
        check_eq("rdata_hold", done_rdata, 64'h0000_0001_0000_0010);

        // Carry between first H and L forces one retry
        mode = 1; roll_armed = 1; m_mtime = 64'h0000_0000_FFFF_FFFF;
        run_cmd(2'd0, 64'd0, 0, lat, rd, er);
        check_eq("roll_lat", 64'(lat), 64'd12);
        check_eq("roll_data", rd, 64'h0000_0001_0000_0000);
        check_eq("roll_err", 64'(er), 64'd0);
        check_eq("roll_nacc", 64'(n_acc), 64'd5);

        // Write, with a command poked mid-sequence that must be ignored
        mode = 0; m_mtimecmp = 64'h0000_0009_0000_0009;
        run_cmd(2'd2, 64'h0000_0002_0000_0005, 1, lat, rd, er);
        check_eq("wr_lat", 64'(lat), 64'd8);
        check_eq("wr_rdata", rd, 64'd0);
        check_eq("wr_err", 64'(er), 64'd0);
        check_eq("wr_nacc", 64'(n_acc), 64'd3);
        check_eq("wr_a0", {log_addr[0], log_wdata[0]}, 64'h0200_4000_FFFF_FFFF);
        check_eq("wr_a1", {log_addr[1], log_wdata[1]}, 64'h0200_4004_0000_0002);
        check_eq("wr_a2", {log_addr[2], log_wdata[2]}, 64'h0200_4000_0000_0005);
        check_eq("wr_wen", 64'({log_wen[0], log_wen[1], log_wen[2]}), 64'd7);
        check_eq("wr_mtimecmp", m_mtimecmp, 64'h0000_0002_0000_0005);
        d_before = n_done;
        repeat (4) @(posedge clk); #1;
        check_eq("busy_cmd_ignored", 64'(n_done - d_before), 64'd0);
        check_eq("busy_cmd_noacc", 64'(n_acc), 64'd3);

        // High word moves on every H read: retries exhausted
        mode = 2; m_mtime = 64'h0000_0000_0000_1234;
        run_cmd(2'd0, 64'd0, 0, lat, rd, er);
        check_eq("inc_lat", 64'(lat), 64'd24);
        check_eq("inc_err", 64'(er), 64'd1);
        check_eq("inc_data", rd, 64'h0000_0005_0000_1234);
        check_eq("inc_nacc", 64'(n_acc), 64'd11);

        // Stalled handshakes on both request and response
        mode = 0; stall = 1;
        run_cmd(2'd1, 64'd0, 0, lat, rd, er);
        stall = 0;
        check_eq("stall_lat", 64'(lat), 64'd23);
        check_eq("stall_data", rd, 64'h0000_0002_0000_0005);
        check_eq("stall_err", 64'(er), 64'd0);
        check_eq("stall_nacc", 64'(n_acc), 64'd3);
        check_eq("stall_stable", 64'(stab_err), 64'd0);

        // Reserved op
        run_cmd(2'd3, 64'd0, 0, lat, rd, er);
        check_eq("rsvd_lat", 64'(lat), 64'd2);
        check_eq("rsvd_err", 64'(er), 64'd1);
        check_eq("rsvd_data", rd, 64'd0);
        check_eq("rsvd_nacc", 64'(n_acc), 64'd0);

        // Reset during WAIT of write step 1
        m_mtimecmp = 64'h0000_0007_0000_0009;
        n_acc = 0;
        d_before = n_done;
        @(negedge clk);
        cmd_op = 2'd2; cmd_wdata = 64'h0000_0003_0000_0006; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tmo = 0;
        while (n_acc < 2 && tmo < 100) begin
            @(negedge clk); #1;
            tmo++;
        end
        check_eq("rst_mid_reached", 64'(n_acc), 64'd2);
        rst_n = 1'b0;
        #1;
        check_eq("rstm_req_valid", 64'(req_valid), 64'd0);
        check_eq("rstm_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rstm_req", {req_addr, req_wdata}, 64'd0);
        check_eq("rstm_req_wen", 64'(req_wen), 64'd0);
        check_eq("rstm_done", {done_rdata[62:0], done_err}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        check_eq("rstm_no_done", 64'(n_done - d_before), 64'd0);
        check_eq("rstm_model", m_mtimecmp, 64'h0000_0003_FFFF_FFFF);
        run_cmd(2'd1, 64'd0, 0, lat, rd, er);
        check_eq("rstm_readback", rd, 64'h0000_0003_FFFF_FFFF);
        check_eq("rstm_rb_err", 64'(er), 64'd0);

        check_eq("single_outstanding", 64'(outst_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clint_access_master.md
# clint_access_master

Initiator side of the 32-bit MMIO device port, sitting between the core's timer-access logic and the CLINT responder. It turns one 64-bit command (read mtime, read mtimecmp, write mtimecmp) into the architecturally safe sequence of 32-bit MMIO accesses, then returns a single 64-bit result. Reads use the hi-lo-hi retry method so the 64-bit value is never torn across a carry. Writes use the low-to-all-ones, high, low order so no spurious timer match can occur mid-update.

## Interface
- MAX_RETRY, default 4: number of extra lo/hi re-reads allowed before the command aborts with an error.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_op  in  2  command code (ClintOp): 0 = RD_MTIME, 1 = RD_MTIMECMP, 2 = WR_MTIMECMP, 3 is reserved.
- cmd_wdata  in  64  new mtimecmp value (WR_MTIMECMP only).
- done_valid  out  1  one-cycle completion pulse.
- done_rdata  out  64  assembled read value; 0 for writes.
- done_err  out  1  retry limit exceeded or reserved op; valid with done_valid.
- req_valid  out  1  MMIO request valid.
- req_ready  in  1  MMIO request accepted this cycle when high with req_valid.
- req_addr  out  Addr (32)  MMIO byte address.
- req_wen  out  1  write request.
- req_wdata  out  32  write data.
- resp_valid  in  1  response qualifier.
- resp_rdata  in  32  read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE; a 2-bit step index selects the access within a sequence.
- IDLE: cmd_ready=1. On cmd_valid, latch op and wdata, clear the retry count, and go to ISSUE at step 0. Reserved op goes straight to DONE with done_err=1.
- ISSUE: hold req_valid=1 with stable addr, wen and wdata until req_ready, then go to WAIT.
- WAIT: the first cycle after acceptance with resp_valid=1 completes the access and captures resp_rdata. Then advance the step, or go to DONE.
- Read sequence (base = CLINT_MTIME or CLINT_MTIMECMP):
  - step 0 reads H into hi1.
  - step 1 reads L into lo.
  - step 2 reads H into hi2.
  - If hi2==hi1, the result is {hi1,lo}.
  - Otherwise hi1:=hi2, retry+1, and go back to step 1. If retry would exceed MAX_RETRY, go to DONE with err=1 and rdata={hi2,lo}.
- Write sequence:
  - step 0 writes CLINT_MTIMECMP with 32'hFFFF_FFFF.
  - step 1 writes CLINT_MTIMECMPH with wdata[63:32].
  - step 2 writes CLINT_MTIMECMP with wdata[31:0].
  - Write responses are still waited for, and their data is ignored.
- DONE: done_valid=1 for exactly one cycle, then IDLE.
- Exactly one MMIO access is outstanding at any time; req_valid is never high in WAIT.

## Timing
- Reset values: state=IDLE, cmd_ready=1, req_valid=0, req_wen=0, req_addr=0, req_wdata=0, done_valid=0, done_rdata=0, done_err=0, retry=0.
- With a responder that has req_ready=1 and resp_valid=1 always, each access takes 2 cycles (ISSUE, WAIT).
  - Clean read: command accept cycle, then 6 cycles, then 1 DONE cycle; done_valid is asserted 8 cycles after cmd handshake.
  - Each read retry adds 4 cycles. A write takes the same 8 cycles.
- cmd_valid while not in IDLE is ignored; the command is not consumed.
- resp_valid high in the ISSUE cycle, or before acceptance, is ignored.
- Reset mid-sequence aborts immediately: no done pulse, req_valid drops asynchronously, and mtimecmp may be left at all-ones low (software reissues).
- done_rdata and done_err hold their values until the next DONE.

## Structure
- Shared package (memorymap): CLINT_MTIME/MTIMEH/MTIMECMP/MTIMECMPH constants, the Addr typedef, and the ClintOp enum.
- No sub-module: a single FSM plus datapath registers (hi1, lo, wdata latch, retry counter).

## Test plan
- RD_MTIME, device mtime=64'h0000_0001_0000_0010 constant, always-ready -> done_valid at cycle +8, rdata=64'h0000_0001_0000_0010, err=0, 3 reads in order H,L,H.
- RD_MTIME with mtime rolling 0x0000_0000_FFFF_FFFF→0x0000_0001_0000_0000 between first H and L -> one retry, rdata=64'h0000_0001_0000_0000, done at cycle +12.
- WR_MTIMECMP 64'h0000_0002_0000_0005 -> writes (MTIMECMP,FFFF_FFFF),(MTIMECMPH,0000_0002),(MTIMECMP,0000_0005); device mtimecmp ends 64'h0000_0002_0000_0005; done_rdata=0.
- Device with hi incrementing on every H read, MAX_RETRY=4 -> exactly 4 retries, done_err=1.
- req_ready held low 3 cycles and resp_valid delayed 2 cycles on each access -> addr/wdata stable while stalled, correct result, no second outstanding request.
- rst_n asserted during WAIT of step 1 of a write -> all outputs reach reset values with no done pulse; a RD_MTIMECMP after reset returns low=FFFF_FFFF, high=new value.
